wartezustand_speicher: RTL and testbench

WARTEZUSTAND_SPEICHER -- requirements
Module: wartezustand_speicher

---
 rtl/wartezustand_speicher.sv | 136 +++++++++++++
 tb/tb_wartezustand_speicher.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wartezustand_speicher.sv
// Word memory with a fixed-latency request/response handshake (LEER -> WARTEN -> ANTWORT -> ABSCHLUSS).
// Optional out-of-range address checking with an Adressfehler pulse is enabled by defining ADRESSPRUEFUNG_EN.
module wartezustand_speicher #(
    parameter int WORDSIZE = 32,
    parameter int WORDS    = 256,
    parameter int LATENZ   = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                LesenAn,
    input  logic                SchreibenAn,
    input  logic [31:0]         Adresse,
    input  logic [WORDSIZE-1:0] DatenRein,
    output logic [WORDSIZE-1:0] DatenRaus,
    output logic                DatenBereit,
    output logic                DatenGeschrieben,
    output logic                Besetzt
`ifdef ADRESSPRUEFUNG_EN
    ,
    output logic                Adressfehler
`endif
);

    localparam int AW = $clog2(WORDS);

    typedef enum logic [1:0] {
        LEER,
        WARTEN,
        ANTWORT,
        ABSCHLUSS
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [WORDSIZE-1:0] data_q, data_d;
    logic [WORDSIZE-1:0] rdata_q, rdata_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic                addr_bad;
    logic                mem_we;

    logic [WORDSIZE-1:0] mem [WORDS];

`ifdef ADRESSPRUEFUNG_EN
    assign addr_bad = (Adresse[31:AW] != '0);
`else
    // Upper address bits are deliberately dropped so accesses wrap modulo WORDS.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Adresse[31:AW];
    assign addr_bad         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = write_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            LEER: begin
                if (LesenAn || SchreibenAn) begin
                    addr_d  = Adresse[AW-1:0];
                    data_d  = DatenRein;
                    write_d = SchreibenAn;
                    err_d   = addr_bad;
                    cnt_d   = 4'(LATENZ - 1);
                    state_d = WARTEN;
                end
            end
            WARTEN: begin
                // The memory access happens on the edge that enters ANTWORT.
                if (cnt_q == 4'd0) begin
                    state_d = ANTWORT;
                    if (write_q) begin
                        mem_we = !err_q;
                    end else begin
                        rdata_d = err_q ? '0 : mem[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ANTWORT: begin
                state_d = ABSCHLUSS;
            end
            ABSCHLUSS: begin
                if (!LesenAn && !SchreibenAn) begin
                    state_d = LEER;
                end
            end
            default: begin
                state_d = LEER;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= LEER;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    // Storage keeps its contents across Reset.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    assign DatenRaus        = rdata_q;
    assign DatenBereit      = (state_q == ANTWORT) && !write_q;
    assign DatenGeschrieben = (state_q == ANTWORT) && write_q;
    assign Besetzt          = (state_q != LEER);
`ifdef ADRESSPRUEFUNG_EN
    assign Adressfehler     = (state_q == ANTWORT) && err_q;
`endif

endmodule

// File: tb/tb_wartezustand_speicher.sv
// Self-checking bench for wartezustand_speicher: a LATENZ=2 instance driven with directed and random
// transactions against an array model, plus a small LATENZ=1 instance for back-to-back reads.
module tb_wartezustand_speicher;

    localparam int WS  = 32;
    localparam int NW  = 256;
    localparam int LAT = 2;
`ifdef ADRESSPRUEFUNG_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        Reset;
    logic        LesenAn, SchreibenAn;
    logic [31:0] Adresse;
    logic [WS-1:0] DatenRein, DatenRaus;
    logic        DatenBereit, DatenGeschrieben, Besetzt;
    logic        Adressfehler;

    logic        f_rd, f_wr;
    logic [31:0] f_addr;
    logic [7:0]  f_din, f_dout;
    logic        f_bereit, f_geschrieben, f_busy;
    logic        f_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_model [NW];
    logic [31:0] last_read;
    logic [7:0]  fmem_model [4];
    logic [7:0]  f_last;

    always #5 clk = ~clk;

    wartezustand_speicher #(.WORDSIZE(WS), .WORDS(NW), .LATENZ(LAT)) u_dut (
        .Clock           (clk),
        .Reset           (Reset),
        .LesenAn         (LesenAn),
        .SchreibenAn     (SchreibenAn),
        .Adresse         (Adresse),
        .DatenRein       (DatenRein),
        .DatenRaus       (DatenRaus),
        .DatenBereit     (DatenBereit),
        .DatenGeschrieben(DatenGeschrieben),
        .Besetzt         (Besetzt)
`ifdef ADRESSPRUEFUNG_EN
        ,
        .Adressfehler    (Adressfehler)
`endif
    );

    wartezustand_speicher #(.WORDSIZE(8), .WORDS(4), .LATENZ(1)) u_fast (
        .Clock           (clk),
        .Reset           (Reset),
        .LesenAn         (f_rd),
        .SchreibenAn     (f_wr),
        .Adresse         (f_addr),
        .DatenRein       (f_din),
        .DatenRaus       (f_dout),
        .DatenBereit     (f_bereit),
        .DatenGeschrieben(f_geschrieben),
        .Besetzt         (f_busy)
`ifdef ADRESSPRUEFUNG_EN
        ,
        .Adressfehler    (f_err)
`endif
    );

`ifndef ADRESSPRUEFUNG_EN
    assign Adressfehler = 1'b0;
    assign f_err        = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on the LATENZ=2 instance; request held for 'hold' cycles past the response.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] data, input int hold);
        bit          bad;
        int          idx;
        int          drop;
        int          free;
        logic [31:0] exp_rd;
        bad    = CHK && (addr >= NW);
        idx    = int'(addr % NW);
        drop   = LAT + hold;
        free   = (LAT + 2 > drop + 1) ? LAT + 2 : drop + 1;
        exp_rd = bad ? 32'h0 : mem_model[idx];
        checkOutput("idle_before", {31'b0, Besetzt}, 32'd0);
        LesenAn     = rd;
        SchreibenAn = wr;
        Adresse     = addr;
        DatenRein   = data;
        @(posedge clk); #1;
        checkOutput("busy_accept", {31'b0, Besetzt}, 32'd1);
        Adresse   = $urandom;
        DatenRein = $urandom;
        for (int k = 1; k <= free; k++) begin
            @(posedge clk); #1;
            checkOutput("rd_pulse", {31'b0, DatenBereit}, {31'b0, (k == LAT) && !wr});
            checkOutput("wr_pulse", {31'b0, DatenGeschrieben}, {31'b0, (k == LAT) && wr});
            if (k == LAT && !wr) last_read = exp_rd;
            checkOutput("rdata", DatenRaus, last_read);
            checkOutput("busy", {31'b0, Besetzt}, {31'b0, k < free});
`ifdef ADRESSPRUEFUNG_EN
            checkOutput("addr_err", {31'b0, Adressfehler}, {31'b0, (k == LAT) && bad});
`endif
            if (k == drop) begin
                LesenAn     = 1'b0;
                SchreibenAn = 1'b0;
            end
        end
        if (wr && !bad) mem_model[idx] = data;
    endtask

    // One transaction on the LATENZ=1 instance, request dropped right after the response.
    task automatic fastStimulus(input bit wr, input int addr, input logic [7:0] data);
        logic [7:0] exp_rd;
        exp_rd = fmem_model[addr];
        checkOutput("f_idle", {31'b0, f_busy}, 32'd0);
        f_rd   = !wr;
        f_wr   = wr;
        f_addr = 32'(addr);
        f_din  = data;
        @(posedge clk); #1;
        f_din = 8'($urandom);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checkOutput("f_rd_pulse", {31'b0, f_bereit}, {31'b0, (k == 1) && !wr});
            checkOutput("f_wr_pulse", {31'b0, f_geschrieben}, {31'b0, (k == 1) && wr});
            if (k == 1 && !wr) f_last = exp_rd;
            checkOutput("f_rdata", {24'b0, f_dout}, {24'b0, f_last});
            checkOutput("f_busy", {31'b0, f_busy}, {31'b0, k < 3});
            if (k == 1) begin
                f_rd = 1'b0;
                f_wr = 1'b0;
            end
        end
        if (wr) fmem_model[addr] = data;
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] raddr;
        int          r;

        Reset = 1'b1;
        LesenAn = 1'b0; SchreibenAn = 1'b0; Adresse = '0; DatenRein = '0;
        f_rd = 1'b0; f_wr = 1'b0; f_addr = '0; f_din = '0;
        last_read = '0;
        f_last    = '0;
        #1;
        checkOutput("reset_busy", {31'b0, Besetzt}, 32'd0);
        checkOutput("reset_rdata", DatenRaus, 32'd0);
        checkOutput("reset_rd_pulse", {31'b0, DatenBereit}, 32'd0);
        checkOutput("reset_wr_pulse", {31'b0, DatenGeschrieben}, 32'd0);
        @(posedge clk); #1;
        Reset = 1'b0;

        $display("[TB] prefill memory");
        for (int a = 0; a < NW; a++) applyStimulus(1'b0, 1'b1, 32'(a), $urandom, 0);

        $display("[TB] write/read DEADBEEF at 5");
        applyStimulus(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 0);
        applyStimulus(1'b1, 1'b0, 32'd5, 32'h0, 0);
        checkOutput("deadbeef", DatenRaus, 32'hDEADBEEF);

        $display("[TB] simultaneous read and write at 7");
        applyStimulus(1'b1, 1'b1, 32'd7, 32'h11, 0);
        applyStimulus(1'b1, 1'b0, 32'd7, 32'h0, 0);
        checkOutput("both_req", DatenRaus, 32'h11);

        $display("[TB] read held ten cycles past response");
        applyStimulus(1'b1, 1'b0, 32'd5, 32'h0, 10);

        $display("[TB] reset during wait state");
        prev = mem_model[3];
        SchreibenAn = 1'b1; Adresse = 32'd3; DatenRein = 32'h5;
        @(posedge clk); #1;
        checkOutput("rst_busy_pre", {31'b0, Besetzt}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("rst_busy", {31'b0, Besetzt}, 32'd0);
        checkOutput("rst_rdata", DatenRaus, 32'd0);
        last_read = '0;
        f_last    = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput("rst_wr_pulse", {31'b0, DatenGeschrieben}, 32'd0);
            checkOutput("rst_rd_pulse", {31'b0, DatenBereit}, 32'd0);
        end
        SchreibenAn = 1'b0;
        Reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'd3, 32'h0, 0);
        checkOutput("rst_no_write", DatenRaus, prev);

        $display("[TB] out-of-range write to 258");
        prev = mem_model[2];
        applyStimulus(1'b0, 1'b1, 32'd258, 32'hAA, 0);
        applyStimulus(1'b1, 1'b0, 32'd2, 32'h0, 0);
`ifdef ADRESSPRUEFUNG_EN
        checkOutput("oor_addr2", DatenRaus, prev);
`else
        checkOutput("wrap_addr2", DatenRaus, 32'hAA);
`endif
        applyStimulus(1'b1, 1'b0, 32'd258, 32'h0, 0);
`ifdef ADRESSPRUEFUNG_EN
        checkOutput("oor_read", DatenRaus, 32'h0);
`else
        checkOutput("wrap_read", DatenRaus, 32'hAA);
`endif

        $display("[TB] random transactions");
        for (int n = 0; n < 80; n++) begin
            r     = $urandom_range(0, 9);
            raddr = 32'($urandom_range(0, NW - 1));
            if ($urandom_range(0, 7) == 0) raddr = raddr | (32'($urandom_range(1, 255)) << 8);
            applyStimulus(r < 4 || r >= 8, r >= 4, raddr, $urandom, $urandom_range(0, 3));
        end

        $display("[TB] LATENZ=1 back-to-back reads");
        for (int a = 0; a < 4; a++) begin
            fastStimulus(1'b1, a, 8'($urandom));
            @(posedge clk); #1;
        end
        for (int a = 0; a < 4; a++) begin
            fastStimulus(1'b0, a, 8'h00);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
